mem_stage_lsu: RTL

MEM-stage load/store unit for the 64-bit RISC-V pipeline. It consumes the EX/MEM pipeline register outputs and issues one data-memory access per instruction over a req/ack bus. Loads are sign- or zero-extended by funct3; stores get byte-enable masks. Results go to the MEM/WB outputs, and `stall` freezes the upstream stages while a bus access is outstanding.

---
 rtl/mem_stage_lsu.sv | 221 ++++++++++++++++++++++
 1 files changed

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: one data-memory access per instruction over a
// req/ack bus, load extension, store lane placement, timeout and fault codes.
//
// state | meaning
// IDLE  | waiting for an EX/MEM instruction; non-memory ops and faults retire here
// BUS   | access outstanding; dmem_* held until ack or wait budget exhausted
module mem_stage_lsu #(
  parameter int MAX_WAIT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic        in_mem_read,
  input  logic        in_mem_write,
  input  logic [2:0]  in_funct3,
  input  logic [63:0] in_alu_result,
  input  logic [63:0] in_rd2,
  input  logic [4:0]  in_wr,
  input  logic        in_reg_write,
  output logic        stall,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [63:0] dmem_addr,
  output logic [63:0] dmem_wdata,
  output logic [7:0]  dmem_be,
  input  logic        dmem_ack,
  input  logic [63:0] dmem_rdata,
  output logic        wb_valid,
  output logic        wb_reg_write,
  output logic [4:0]  wb_wr,
  output logic [63:0] wb_data,
  output logic        mem_fault,
  output logic [1:0]  fault_code
);

  localparam int CW = $clog2(MAX_WAIT + 1);

  typedef enum logic {S_IDLE, S_BUS} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          req_q, req_d, we_q, we_d;
  logic [63:0]   addr_q, addr_d, wdata_q, wdata_d;
  logic [7:0]    be_q, be_d;
  logic [2:0]    off_q, off_d, f3_q, f3_d;
  logic [4:0]    wr_q, wr_d, wbwr_q, wbwr_d;
  logic          rw_q, rw_d, wbv_q, wbv_d, wbrw_q, wbrw_d, fault_q, fault_d;
  logic [63:0]   wbdata_q, wbdata_d;
  logic [1:0]    code_q, code_d;

  logic          is_mem, illegal, misal, legal_op;
  logic [7:0]    st_be;
  logic [63:0]   st_wdata, lane, ld_data;

  // Decode the EX/MEM slot: legality, alignment and store lane placement.
  always_comb begin
    is_mem  = in_mem_read | in_mem_write;
    illegal = (in_mem_read & in_mem_write) |
              (in_mem_read & (in_funct3 == 3'b111)) |
              (in_mem_write & in_funct3[2]);
    case (in_funct3[1:0])
      2'b01:   misal = in_alu_result[0];
      2'b10:   misal = |in_alu_result[1:0];
      2'b11:   misal = |in_alu_result[2:0];
      default: misal = 1'b0;
    endcase
    legal_op = in_valid & is_mem & ~illegal & ~misal;
    case (in_funct3[1:0])
      2'b00:   st_be = 8'h01;
      2'b01:   st_be = 8'h03;
      2'b10:   st_be = 8'h0F;
      default: st_be = 8'hFF;
    endcase
    st_be    = st_be << in_alu_result[2:0];
    st_wdata = in_rd2 << {in_alu_result[2:0], 3'b000};
    stall    = ((state_q == S_IDLE) & legal_op) | ((state_q == S_BUS) & ~dmem_ack);
  end

  // Extract the addressed lane of the read doubleword and extend it.
  always_comb begin
    lane = dmem_rdata >> {off_q, 3'b000};
    case (f3_q)
      3'b000:  ld_data = {{56{lane[7]}}, lane[7:0]};
      3'b001:  ld_data = {{48{lane[15]}}, lane[15:0]};
      3'b010:  ld_data = {{32{lane[31]}}, lane[31:0]};
      3'b100:  ld_data = {56'd0, lane[7:0]};
      3'b101:  ld_data = {48'd0, lane[15:0]};
      3'b110:  ld_data = {32'd0, lane[31:0]};
      default: ld_data = lane;
    endcase
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    req_d    = req_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    be_d     = be_q;
    off_d    = off_q;
    f3_d     = f3_q;
    wr_d     = wr_q;
    rw_d     = rw_q;
    wbv_d    = 1'b0;
    wbrw_d   = wbrw_q;
    wbwr_d   = wbwr_q;
    wbdata_d = wbdata_q;
    fault_d  = 1'b0;
    code_d   = code_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          if (!is_mem) begin
            wbv_d    = 1'b1;
            wbdata_d = in_alu_result;
            wbwr_d   = in_wr;
            wbrw_d   = in_reg_write;
          end else if (illegal | misal) begin
            wbv_d   = 1'b1;
            wbrw_d  = 1'b0;
            wbwr_d  = in_wr;
            fault_d = 1'b1;
            code_d  = illegal ? 2'b11 : 2'b01;
          end else begin
            state_d = S_BUS;
            cnt_d   = '0;
            req_d   = 1'b1;
            we_d    = in_mem_write;
            addr_d  = {in_alu_result[63:3], 3'b000};
            off_d   = in_alu_result[2:0];
            be_d    = in_mem_write ? st_be : 8'hFF;
            wdata_d = in_mem_write ? st_wdata : 64'd0;
            f3_d    = in_funct3;
            wr_d    = in_wr;
            rw_d    = in_reg_write;
          end
        end
      end
      default: begin
        if (dmem_ack) begin
          state_d = S_IDLE;
          req_d   = 1'b0;
          wbv_d   = 1'b1;
          wbwr_d  = wr_q;
          if (we_q) begin
            wbrw_d = 1'b0;
          end else begin
            wbrw_d   = rw_q;
            wbdata_d = ld_data;
          end
        end else if (cnt_q == CW'(MAX_WAIT - 1)) begin
          state_d = S_IDLE;
          req_d   = 1'b0;
          wbv_d   = 1'b1;
          wbrw_d  = 1'b0;
          wbwr_d  = wr_q;
          fault_d = 1'b1;
          code_d  = 2'b10;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    endcase
  end

  // State and output registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      req_q    <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      be_q     <= '0;
      off_q    <= '0;
      f3_q     <= '0;
      wr_q     <= '0;
      rw_q     <= 1'b0;
      wbv_q    <= 1'b0;
      wbrw_q   <= 1'b0;
      wbwr_q   <= '0;
      wbdata_q <= '0;
      fault_q  <= 1'b0;
      code_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      req_q    <= req_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      be_q     <= be_d;
      off_q    <= off_d;
      f3_q     <= f3_d;
      wr_q     <= wr_d;
      rw_q     <= rw_d;
      wbv_q    <= wbv_d;
      wbrw_q   <= wbrw_d;
      wbwr_q   <= wbwr_d;
      wbdata_q <= wbdata_d;
      fault_q  <= fault_d;
      code_q   <= code_d;
    end
  end

  assign dmem_req     = req_q;
  assign dmem_we      = we_q;
  assign dmem_addr    = addr_q;
  assign dmem_wdata   = wdata_q;
  assign dmem_be      = be_q;
  assign wb_valid     = wbv_q;
  assign wb_reg_write = wbrw_q;
  assign wb_wr        = wbwr_q;
  assign wb_data      = wbdata_q;
  assign mem_fault    = fault_q;
  assign fault_code   = code_q;

endmodule
